// File: rtl/ssd_scroll_word.sv
// Scrolling 4-digit common-anode seven-segment driver: ASCII message -> multiplexed SEG/AN/DP pins.
// Latency: one cycle from any counter/pos/msg change to the registered pins.
// Backpressure: none; the scan runs freely and load/scroll_en are sampled every cycle.
module ssd_scroll_word #(
    parameter int MSG_CHARS  = 8,
    parameter int SCAN_DIV   = 100000,
    parameter int SCROLL_DIV = 25000000,
    parameter int GUARD      = 2
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [8*MSG_CHARS-1:0] word,
    input  logic                   load,
    input  logic                   scroll_en,
    input  logic [3:0]             dp_mask,
    output logic [6:0]             SEG,
    output logic [3:0]             AN,
    output logic                   DP,
    output logic                   wrap
);

    // Counter and index widths; MSG_CHARS >= 4 keeps PW >= 2.
    localparam int PW  = $clog2(MSG_CHARS);
    localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int SRW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

    localparam logic [PW-1:0]          POS_LAST    = PW'(MSG_CHARS - 1);
    localparam logic [PW:0]            MSG_LEN     = (PW+1)'(MSG_CHARS);
    localparam logic [SCW-1:0]         SCAN_LAST   = SCW'(SCAN_DIV - 1);
    localparam logic [SCW-1:0]         GUARD_END   = SCW'(GUARD);
    localparam logic [SRW-1:0]         SCROLL_LAST = SRW'(SCROLL_DIV - 1);
    localparam logic [8*MSG_CHARS-1:0] MSG_BLANK   = {MSG_CHARS{8'h20}};

    // Architectural state
    logic [8*MSG_CHARS-1:0] msg_q,    msg_d;
    logic [PW-1:0]          pos_q,    pos_d;
    logic [1:0]             digit_q,  digit_d;
    logic [SCW-1:0]         scan_q,   scan_d;
    logic [SRW-1:0]         scroll_q, scroll_d;

    // Registered pins
    logic [6:0] seg_q, seg_d;
    logic [3:0] an_q,  an_d;
    logic       dp_q,  dp_d;
    logic       wrap_q, wrap_d;

    // Datapath intermediates
    logic       scroll_step;
    logic       in_guard;
    logic [1:0] digit_off;
    logic [PW:0] char_sum;
    logic [PW:0] char_sel;
    logic [7:0]  cur_char;

    // ASCII -> lit segments {g,f,e,d,c,b,a}; letters are folded to lower case first.
    function automatic logic [6:0] glyph_lit(input logic [7:0] ch);
        logic [7:0] c;
        logic [6:0] lit;
        c = ((ch >= 8'h41) && (ch <= 8'h5A)) ? (ch + 8'h20) : ch;
        case (c)
            "0":     lit = 7'b0111111;
            "1":     lit = 7'b0000110;
            "2":     lit = 7'b1011011;
            "3":     lit = 7'b1001111;
            "4":     lit = 7'b1100110;
            "5":     lit = 7'b1101101;
            "6":     lit = 7'b1111101;
            "7":     lit = 7'b0000111;
            "8":     lit = 7'b1111111;
            "9":     lit = 7'b1101111;
            "a":     lit = 7'b1110111;
            "b":     lit = 7'b1111100;
            "c":     lit = 7'b0111001;
            "d":     lit = 7'b1011110;
            "e":     lit = 7'b1111001;
            "f":     lit = 7'b1110001;
            "g":     lit = 7'b0111101;
            "h":     lit = 7'b1110100;
            "i":     lit = 7'b0010000;
            "j":     lit = 7'b0001110;
            "l":     lit = 7'b0111000;
            "m":     lit = 7'b1010101;
            "n":     lit = 7'b1010100;
            "o":     lit = 7'b1011100;
            "p":     lit = 7'b1110011;
            "r":     lit = 7'b1010000;
            "s":     lit = 7'b1101101;
            "t":     lit = 7'b1111000;
            "u":     lit = 7'b0011100;
            "y":     lit = 7'b1101110;
            "-":     lit = 7'b1000000;
            "_":     lit = 7'b0001000;
            " ":     lit = 7'b0000000;
            default: lit = 7'b1001001;  // a, d, g: unknown-character marker
        endcase
        return lit;
    endfunction

    // Digit scan: slot counter and digit rotation; untouched by load.
    always_comb begin
        scan_d  = scan_q;
        digit_d = digit_q;
        if (scan_q == SCAN_LAST) begin
            scan_d  = '0;
            digit_d = digit_q + 2'd1;
        end else begin
            scan_d = scan_q + SCW'(1);
        end
    end

    // Message capture and scroll; a load wins over a coincident scroll step.
    always_comb begin
        msg_d       = msg_q;
        pos_d       = pos_q;
        scroll_d    = scroll_q;
        scroll_step = scroll_en && (scroll_q == SCROLL_LAST);
        wrap_d      = 1'b0;
        if (load) begin
            msg_d    = word;
            pos_d    = '0;
            scroll_d = '0;
        end else if (scroll_en) begin
            if (scroll_step) begin
                scroll_d = '0;
                pos_d    = (pos_q == POS_LAST) ? '0 : (pos_q + PW'(1));
                wrap_d   = (pos_q == POS_LAST);
            end else begin
                scroll_d = scroll_q + SRW'(1);
            end
        end
    end

    // Pick the character for the digit being scanned: index (pos + 3 - digit) mod MSG_CHARS.
    always_comb begin
        digit_off = 2'd3 - digit_q;
        char_sum  = {1'b0, pos_q} + (PW+1)'(digit_off);
        char_sel  = (char_sum >= MSG_LEN) ? (char_sum - MSG_LEN) : char_sum;
        cur_char  = 8'h20;
        for (int i = 0; i < MSG_CHARS; i++) begin
            if (char_sel == (PW+1)'(i)) begin
                cur_char = msg_q[8*(MSG_CHARS-1-i) +: 8];
            end
        end
    end

    // Pin values: everything blanked during the guard window at the start of each slot.
    always_comb begin
        in_guard = (scan_q < GUARD_END);
        an_d     = 4'hF;
        seg_d    = 7'h7F;
        dp_d     = 1'b1;
        if (!in_guard) begin
            an_d  = ~(4'b0001 << digit_q);
            seg_d = ~glyph_lit(cur_char);
            dp_d  = ~dp_mask[digit_q];
        end
    end

    // State and pin registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            msg_q    <= MSG_BLANK;
            pos_q    <= '0;
            digit_q  <= '0;
            scan_q   <= '0;
            scroll_q <= '0;
            seg_q    <= 7'h7F;
            an_q     <= 4'hF;
            dp_q     <= 1'b1;
            wrap_q   <= 1'b0;
        end else begin
            msg_q    <= msg_d;
            pos_q    <= pos_d;
            digit_q  <= digit_d;
            scan_q   <= scan_d;
            scroll_q <= scroll_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
            dp_q     <= dp_d;
            wrap_q   <= wrap_d;
        end
    end

    assign SEG  = seg_q;
    assign AN   = an_q;
    assign DP   = dp_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_ssd_scroll_word.sv
// Bench for ssd_scroll_word: directed loads/scroll/freeze with a cycle-tagged scoreboard.
// Latency: expectations are tagged with the cycle at which the registered pins must show them.
// Backpressure: none; the monitor checks every negedge independently of stimulus.
module tb_ssd_scroll_word;

    localparam int MSG_CHARS  = 8;
    localparam int SCAN_DIV   = 4;
    localparam int SCROLL_DIV = 20;
    localparam int GUARD      = 1;

    localparam logic [6:0] G_SP = 7'b1111111;
    localparam logic [6:0] G_M  = 7'b0101010;
    localparam logic [6:0] G_E  = 7'b0000110;
    localparam logic [6:0] G_1  = 7'b1111001;
    localparam logic [6:0] G_2  = 7'b0100100;
    localparam logic [6:0] G_3  = 7'b0110000;
    localparam logic [6:0] G_4  = 7'b0011001;
    localparam logic [6:0] G_5  = 7'b0010010;
    localparam logic [6:0] G_0  = 7'b1000000;
    localparam logic [6:0] G_Z  = 7'b0110110;
    localparam logic [6:0] G_DASH = 7'b0111111;
    localparam logic [6:0] G_UND  = 7'b1110111;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] word;
    logic        load;
    logic        scroll_en;
    logic [3:0]  dp_mask;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;
    logic        wrap_o;

    ssd_scroll_word #(
        .MSG_CHARS (MSG_CHARS),
        .SCAN_DIV  (SCAN_DIV),
        .SCROLL_DIV(SCROLL_DIV),
        .GUARD     (GUARD)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .word     (word),
        .load     (load),
        .scroll_en(scroll_en),
        .dp_mask  (dp_mask),
        .SEG      (seg),
        .AN       (an),
        .DP       (dp),
        .wrap     (wrap_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        int         kind;    // 0: pins, 1: wrap pulse count
        int         phase;
        logic [3:0] an;
        logic [6:0] seg;
        logic       seg_chk;
        logic       dp;
        int         wraps;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   wrap_total = 0;

    logic [6:0] gl_abc [8];

    task automatic push_pins(input int c, input int ph, input logic [3:0] a,
                             input logic [6:0] s, input logic sc, input logic d);
        exp_t e;
        e.cyc = c; e.kind = 0; e.phase = ph; e.an = a; e.seg = s;
        e.seg_chk = sc; e.dp = d; e.wraps = 0;
        sb.push_back(e);
    endtask

    task automatic push_wrap(input int c, input int ph, input int n);
        exp_t e;
        e.cyc = c; e.kind = 1; e.phase = ph; e.an = 4'hF; e.seg = 7'h7F;
        e.seg_chk = 1'b0; e.dp = 1'b1; e.wraps = n;
        sb.push_back(e);
    endtask

    // Scan is aligned to the reset release: cycle c shows slot phase (c-4)%4 of digit ((c-4)/4)%4.
    task automatic push_window(input int lo, input int hi, input int ph,
                               input logic [6:0] s3, input logic [6:0] s2,
                               input logic [6:0] s1, input logic [6:0] s0,
                               input logic [3:0] dpm);
        logic [6:0] sv [4];
        sv[0] = s0; sv[1] = s1; sv[2] = s2; sv[3] = s3;
        for (int c = lo; c <= hi; c++) begin
            int sp;
            int dg;
            sp = (c - 4) % 4;
            dg = ((c - 4) / 4) % 4;
            if (sp == 0) push_pins(c, ph, 4'hF, 7'h7F, 1'b0, 1'b1);
            else         push_pins(c, ph, ~(4'b0001 << dg), sv[dg], 1'b1, ~dpm[dg]);
        end
    endtask

    task automatic check_entry(input exp_t e);
        checks++;
        if (e.cyc != cyc) begin
            errors++;
            $display("FAIL sb_missed phase=%0d: checked at cycle %0d, required cycle %0d", e.phase, cyc, e.cyc);
        end else if (e.kind == 0) begin
            if (an !== e.an || dp !== e.dp || (e.seg_chk && seg !== e.seg)) begin
                errors++;
                $display("FAIL pins phase=%0d cyc=%0d: got AN=%h SEG=%b DP=%b, want AN=%h SEG=%b DP=%b (seg checked=%0d)",
                         e.phase, cyc, an, seg, dp, e.an, e.seg, e.dp, e.seg_chk);
            end
        end else begin
            if (wrap_total != e.wraps) begin
                errors++;
                $display("FAIL wrap_count phase=%0d cyc=%0d: got %0d pulse cycles, want %0d", e.phase, cyc, wrap_total, e.wraps);
            end
        end
    endtask

    // Monitor: tally wrap, check the single-anode rule, then retire due expectations.
    always @(negedge clk) begin
        if (wrap_o === 1'b1) wrap_total++;
        if (cyc > 0) begin
            checks++;
            if ($countones(~an) > 1) begin
                errors++;
                $display("FAIL one_anode cyc=%0d: got AN=%b, want at most one low", cyc, an);
            end
        end
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                check_entry(sb[i]);
                sb.delete(i);
            end
        end
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    initial begin
        int lb;
        int lf;
        int lr;
        int p;
        gl_abc[0] = 7'b0001000; gl_abc[1] = 7'b0000011; gl_abc[2] = 7'b1000110; gl_abc[3] = 7'b0100001;
        gl_abc[4] = 7'b0000110; gl_abc[5] = 7'b0001110; gl_abc[6] = 7'b1000010; gl_abc[7] = 7'b0001011;

        rst = 1'b1; load = 1'b0; scroll_en = 1'b0; dp_mask = 4'h0;
        word = "zzzzzzzz";

        // Reset: pins at reset values, then one guard cycle, then digit 0 showing a space.
        for (int c = 1; c <= 3; c++) push_pins(c, 0, 4'hF, 7'h7F, 1'b1, 1'b1);
        push_wrap(3, 0, 0);
        push_pins(4, 0, 4'hF, 7'h7F, 1'b1, 1'b1);
        push_window(5, 8, 0, G_SP, G_SP, G_SP, G_SP, 4'h0);
        wait_cyc(3);
        rst = 1'b0;

        // Static word, no scrolling.
        wait_cyc(7);
        word = "  mem   "; load = 1'b1; scroll_en = 1'b0;
        push_window(9, 41, 1, G_SP, G_SP, G_M, G_E, 4'h0);
        wait_cyc(8);
        load = 1'b0;
        word = "xxxxxxxx";

        // Scroll through all positions, wrap, then freeze mid-count.
        lb = 40;
        wait_cyc(lb);
        word = "abcdefgh"; load = 1'b1; scroll_en = 1'b1;
        for (int k = 0; k < 8; k++)
            push_window(lb + 2 + 20*k, lb + 21 + 20*k, 2,
                        gl_abc[k], gl_abc[(k+1)%8], gl_abc[(k+2)%8], gl_abc[(k+3)%8], 4'h0);
        push_window(lb + 162, lb + 231, 3, gl_abc[0], gl_abc[1], gl_abc[2], gl_abc[3], 4'h0);
        for (int k = 1; k < 8; k++) begin
            p = k;
            push_window(lb + 232 + 20*(k-1), lb + 251 + 20*(k-1), 4,
                        gl_abc[p], gl_abc[(p+1)%8], gl_abc[(p+2)%8], gl_abc[(p+3)%8], 4'h0);
        end
        push_wrap(lb + 1, 2, 0);
        push_wrap(lb + 181, 3, 1);
        wait_cyc(lb + 1);
        load = 1'b0;
        wait_cyc(lb + 171);
        scroll_en = 1'b0;
        wait_cyc(lb + 221);
        scroll_en = 1'b1;

        // Load on the cycle of the 7 -> 0 step: no wrap, window restarts at position 0.
        wait_cyc(lb + 370);
        word = "12345678"; load = 1'b1;
        push_window(lb + 372, lb + 391, 5, G_1, G_2, G_3, G_4, 4'h0);
        push_window(lb + 392, lb + 411, 5, G_2, G_3, G_4, G_5, 4'h0);
        push_wrap(lb + 400, 5, 1);
        wait_cyc(lb + 371);
        load = 1'b0;

        // Font corners and decimal point; later word changes without load are ignored.
        lf = lb + 411;
        wait_cyc(lf);
        word = "0Z-_9   "; load = 1'b1; scroll_en = 1'b0; dp_mask = 4'b1000;
        push_window(lf + 2, lf + 33, 6, G_0, G_Z, G_DASH, G_UND, 4'b1000);
        wait_cyc(lf + 1);
        load = 1'b0;
        wait_cyc(lf + 5);
        word = "88888888";

        // Reset mid-operation.
        lr = lf + 34;
        wait_cyc(lr);
        rst = 1'b1; scroll_en = 1'b1;
        for (int c = lr + 1; c <= lr + 3; c++) push_pins(c, 7, 4'hF, 7'h7F, 1'b1, 1'b1);
        push_wrap(lr + 3, 7, 1);
        wait_cyc(lr + 4);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d expectations left, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
